// File: rtl/edge_evt_pkg.sv
// Shared encodings for the edge-event scheduler: channel mode values and output FSM states.
package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/edge_evt_sched_edge_det.sv
// Single-channel edge detector with mode qualification.
// Optional input debounce is enabled by defining DEBOUNCE_EN.
module edge_det
  import edge_evt_pkg::*;
#(
  parameter int DB_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_i,
  input  logic [1:0] mode_i,
  output logic       qualify_o,
  output logic       rise_o
);

  logic prev_q;
  logic prev_d;
  logic det_in_s;
  logic rise_s;
  logic fall_s;
  logic rise_en_s;
  logic fall_en_s;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  // The filtered level follows the input only after DB_CYC consecutive differing cycles.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (in_i != filt_q) begin
      if (cnt_q == CNT_W'(DB_CYC - 1)) begin
        filt_d = in_i;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign det_in_s = filt_q;
`else
  logic [31:0] db_cyc_unused_s;
  assign db_cyc_unused_s = DB_CYC;
  assign det_in_s        = in_i;
`endif

  assign prev_d = det_in_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_s    = det_in_s & ~prev_q;
  assign fall_s    = ~det_in_s & prev_q;
  assign rise_en_s = (mode_i == MODE_RISE) || (mode_i == MODE_ANY);
  assign fall_en_s = (mode_i == MODE_FALL) || (mode_i == MODE_ANY);
  assign qualify_o = (rise_s & rise_en_s) | (fall_s & fall_en_s);
  assign rise_o    = rise_s;

endmodule

// File: rtl/edge_evt_sched.sv
// Multi-channel edge-event scheduler: per-channel pending capture and round-robin
// sharing of one valid/ready event port. Define DEBOUNCE_EN to filter inputs.
module edge_evt_sched
  import edge_evt_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DB_CYC = 16,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in,
  input  logic [2*N_CH-1:0] mode,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CH_W-1:0]   ev_ch,
  output logic              ev_rise,
  output logic [N_CH-1:0]   overrun,
  input  logic              ovr_clr
);

  logic [N_CH-1:0] qual_s;
  logic [N_CH-1:0] rise_s;

  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] pending_d;
  logic [N_CH-1:0] pend_rise_q;
  logic [N_CH-1:0] pend_rise_d;
  logic [N_CH-1:0] overrun_q;
  logic [N_CH-1:0] overrun_d;
  logic [N_CH-1:0] ovr_set_s;
  logic [N_CH-1:0] clr_s;

  state_e          state_q;
  state_e          state_d;
  logic            ev_valid_q;
  logic            ev_valid_d;
  logic [CH_W-1:0] ev_ch_q;
  logic [CH_W-1:0] ev_ch_d;
  logic            ev_rise_q;
  logic            ev_rise_d;
  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;

  logic            sel_found_s;
  logic [CH_W-1:0] sel_idx_s;
  logic [CH_W-1:0] idx_s;
  logic            load_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_det #(
      .DB_CYC(DB_CYC)
    ) u_det (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_i     (in[g]),
      .mode_i   (mode[2*g+1:2*g]),
      .qualify_o(qual_s[g]),
      .rise_o   (rise_s[g])
    );
  end

  // Scan from farthest to nearest so the channel right after ptr wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    idx_s       = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx_s       = CH_W'((int'(ptr_q) + k) % N_CH);
      sel_found_s = sel_found_s | pending_q[idx_s];
      sel_idx_s   = pending_q[idx_s] ? idx_s : sel_idx_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid_q;
    load_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found_s) begin
          load_s     = 1'b1;
          state_d    = S_PRESENT;
          ev_valid_d = 1'b1;
        end else begin
          state_d    = S_IDLE;
          ev_valid_d = 1'b0;
        end
      end
      S_PRESENT: begin
        if (ev_ready) begin
          if (sel_found_s) begin
            load_s     = 1'b1;
            state_d    = S_PRESENT;
            ev_valid_d = 1'b1;
          end else begin
            state_d    = S_IDLE;
            ev_valid_d = 1'b0;
          end
        end else begin
          state_d    = S_PRESENT;
          ev_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        ev_valid_d = 1'b0;
      end
    endcase
    ev_ch_d   = load_s ? sel_idx_s : ev_ch_q;
    ev_rise_d = load_s ? pend_rise_q[sel_idx_s] : ev_rise_q;
    ptr_d     = load_s ? sel_idx_s : ptr_q;
  end

  // A slot being handed to the output this cycle may accept a new edge.
  always_comb begin
    pending_d   = pending_q;
    pend_rise_d = pend_rise_q;
    ovr_set_s   = '0;
    clr_s       = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr_s[i] = load_s && (sel_idx_s == CH_W'(i));
      if (qual_s[i]) begin
        if (!pending_q[i] || clr_s[i]) begin
          pending_d[i]   = 1'b1;
          pend_rise_d[i] = rise_s[i];
        end else begin
          ovr_set_s[i]   = 1'b1;
        end
      end else if (clr_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
    overrun_d = (ovr_clr ? '0 : overrun_q) | ovr_set_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      pend_rise_q <= '0;
      overrun_q   <= '0;
      state_q     <= S_IDLE;
      ev_valid_q  <= 1'b0;
      ev_ch_q     <= '0;
      ev_rise_q   <= 1'b0;
      ptr_q       <= CH_W'(N_CH - 1);
    end else begin
      pending_q   <= pending_d;
      pend_rise_q <= pend_rise_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      ev_valid_q  <= ev_valid_d;
      ev_ch_q     <= ev_ch_d;
      ev_rise_q   <= ev_rise_d;
      ptr_q       <= ptr_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign ev_rise  = ev_rise_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_edge_evt_sched.sv
// Scoreboard bench for edge_evt_sched; the debounce scenario runs when DEBOUNCE_EN is defined.
module tb_edge_evt_sched;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int DB_CYC = 16;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            rise;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   in_s;
  logic [2*N_CH-1:0] mode;
  logic              ev_valid;
  logic              ev_ready;
  logic [CH_W-1:0]   ev_ch;
  logic              ev_rise;
  logic [N_CH-1:0]   overrun;
  logic              ovr_clr;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  hs_cnt   = 0;

  always #5 clk = ~clk;

  edge_evt_sched #(.N_CH(N_CH), .DB_CYC(DB_CYC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_s),
    .mode    (mode),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_ch   (ev_ch),
    .ev_rise (ev_rise),
    .overrun (overrun),
    .ovr_clr (ovr_clr)
  );

  // Called just after a falling edge with inputs set; scores any handshake at the next rising edge.
  task automatic cyc();
    ev_t e;
    #1;
    if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
      hs_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: got ch=%0d rise=%0b, required no event", ev_ch, ev_rise);
      end else begin
        e = exp_q.pop_front();
        if (ev_ch !== e.ch || ev_rise !== e.rise) begin
          n_errors++;
          $display("FAIL event_order: got ch=%0d rise=%0b, required ch=%0d rise=%0b",
                   ev_ch, ev_rise, e.ch, e.rise);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_ev(input int ch, input logic rise);
    ev_t e;
    e.ch   = CH_W'(ch);
    e.rise = rise;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drained: %0d events still outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [N_CH-1:0] in_val, input logic [2*N_CH-1:0] mode_val);
    @(negedge clk);
    rst_n    = 1'b0;
    in_s     = in_val;
    mode     = mode_val;
    ev_ready = 1'b1;
    ovr_clr  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b0 || overrun !== 4'b0000 || ev_ch !== 2'd0 || ev_rise !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: valid=%b overrun=%b ch=%0d rise=%b, required all 0",
               ev_valid, overrun, ev_ch, ev_rise);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4'b0001, 8'h55);
    push_ev(0, 1'b1);
    cyc();
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_early: ev_valid=%b after 1 edge, required 0", ev_valid);
    end
    cyc();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_ch !== 2'd0) begin
      n_errors++;
      $display("FAIL latency_2edge: valid=%b ch=%0d, required valid=1 ch=0", ev_valid, ev_ch);
    end
    cycles(6);
    check_drained("reset_edge");
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0000, 8'hFF);
    in_s = 4'b1010;
    push_ev(1, 1'b1);
    push_ev(3, 1'b1);
    cyc();
    cyc();
    hs_cnt = 0;
    cyc();
    cyc();
    n_checks++;
    if (hs_cnt != 2) begin
      n_errors++;
      $display("FAIL back_to_back: %0d handshakes in 2 cycles, required 2", hs_cnt);
    end
    cycles(3);
    check_drained("b2b_first");
    // ch0 rises and ch3 falls together; pointer sits at 3 so ch0 goes first
    in_s = 4'b0011;
    push_ev(0, 1'b1);
    push_ev(3, 1'b0);
    cycles(6);
    check_drained("b2b_ptr");
  endtask

  task automatic test_backpressure();
    do_reset(4'b0000, 8'hFF);
    ev_ready = 1'b0;
    in_s = 4'b0100;
    cyc();
    in_s = 4'b0000;
    cyc();
    in_s = 4'b0100;
    cyc();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_ch !== 2'd2 || ev_rise !== 1'b1) begin
        n_errors++;
        $display("FAIL hold_stable[%0d]: valid=%b ch=%0d rise=%b, required 1/2/1",
                 i, ev_valid, ev_ch, ev_rise);
      end
      cyc();
    end
    n_checks++;
    if (overrun !== 4'b0100) begin
      n_errors++;
      $display("FAIL overrun_set: got %b, required 0100", overrun);
    end
    push_ev(2, 1'b1);
    push_ev(2, 1'b0);
    ev_ready = 1'b1;
    cycles(6);
    check_drained("backpressure");
    n_checks++;
    if (overrun !== 4'b0100) begin
      n_errors++;
      $display("FAIL overrun_sticky: got %b, required 0100", overrun);
    end
  endtask

  task automatic test_ovr_clr();
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    n_checks++;
    if (overrun !== 4'b0000) begin
      n_errors++;
      $display("FAIL ovr_clr: got %b, required 0000", overrun);
    end
    ev_ready = 1'b0;
    in_s = 4'b0101;
    cyc();
    in_s = 4'b0100;
    cyc();
    in_s    = 4'b0101;
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    n_checks++;
    if (overrun !== 4'b0001) begin
      n_errors++;
      $display("FAIL ovr_set_wins: got %b, required 0001", overrun);
    end
    push_ev(0, 1'b1);
    push_ev(0, 1'b0);
    ev_ready = 1'b1;
    cycles(6);
    check_drained("ovr_clr");
  endtask

  task automatic test_mode();
    do_reset(4'b0000, 8'b0000_0010);
    in_s = 4'b0001;
    cycles(4);
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mode_fall_ignores_rise: ev_valid=%b, required 0", ev_valid);
    end
    in_s = 4'b0000;
    push_ev(0, 1'b0);
    cycles(4);
    check_drained("mode_fall");
    ev_ready = 1'b0;
    mode = 8'h03;
    in_s = 4'b0001;
    cyc();
    in_s = 4'b0000;
    cyc();
    mode = 8'h00;
    in_s = 4'b0001;
    cyc();
    in_s = 4'b0000;
    cyc();
    push_ev(0, 1'b1);
    push_ev(0, 1'b0);
    ev_ready = 1'b1;
    cycles(6);
    check_drained("mode_off");
    n_checks++;
    if (overrun !== 4'b0000) begin
      n_errors++;
      $display("FAIL mode_off_overrun: got %b, required 0000", overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'b0000, 8'hFF);
    ev_ready = 1'b0;
    in_s = 4'b0010;
    cycles(3);
    n_checks++;
    if (ev_valid !== 1'b1 || ev_ch !== 2'd1) begin
      n_errors++;
      $display("FAIL mid_present: valid=%b ch=%0d, required valid=1 ch=1", ev_valid, ev_ch);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: ev_valid=%b, required 0", ev_valid);
    end
    in_s = 4'b0000;
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    cycles(6);
    check_drained("reset_mid");
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    int seen;
    do_reset(4'b0000, 8'hFF);
    in_s = 4'b0001;
    cycles(5);
    in_s = 4'b0000;
    cycles(30);
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_filtered: ev_valid=%b, required 0", ev_valid);
    end
    push_ev(0, 1'b1);
    in_s = 4'b0001;
    seen = -1;
    for (int k = 0; k < 40; k++) begin
      if (seen < 0 && ev_valid === 1'b1) seen = k;
      cyc();
    end
    n_checks++;
    if (seen != DB_CYC + 2) begin
      n_errors++;
      $display("FAIL debounce_latency: first valid after %0d edges, required %0d", seen, DB_CYC + 2);
    end
    check_drained("debounce");
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    in_s     = '0;
    mode     = '0;
    ev_ready = 1'b0;
    ovr_clr  = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_ovr_clr();
    test_mode();
    test_reset_mid();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
